lfsr_stream: RTL and testbench



---
 rtl/lfsr_pkg.sv | 33 +++
 rtl/lfsr_step_unroll.sv | 34 +++
 rtl/lfsr_stream.sv | 153 +++++++++++++++
 tb/tb_lfsr_stream.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// -----------------------------------------------------------------------------
// lfsr_pkg
// Shared types and constants for the lfsr_stream block.
//   lfsr_state_e   : stream FSM state (warm-up or running)
//   LFSR_DEF_*     : default register width, tap polynomial and reset/seed value
//   LFSR_MAX       : widest state the feedback helper handles
//   lfsr_fb()      : feedback bit for one Fibonacci shift (XOR of tapped bits)
// -----------------------------------------------------------------------------
package lfsr_pkg;

    typedef enum logic [0:0] {
        ST_WARMUP,
        ST_RUN
    } lfsr_state_e;

    localparam int unsigned LFSR_DEF_SIZE = 7;
    localparam logic [7:0]  LFSR_DEF_POLY = 8'b11000001;
    localparam logic [6:0]  LFSR_DEF_INIT = 7'b1111010;

    // Upper bound on LFSR_SIZE; callers zero-extend into this width.
    localparam int unsigned LFSR_MAX = 32;

    // Warm-up counter width, enough for 0..255 discarded advances.
    localparam int unsigned WARMUP_CNT_W = 8;

    // Feedback of a single shift. Bits above the real register width must be
    // zero in both arguments so they cannot disturb the parity.
    function automatic logic lfsr_fb(input logic [LFSR_MAX-1:0] state,
                                     input logic [LFSR_MAX-1:0] taps);
        return ^(state & taps);
    endfunction

endpackage

// File: rtl/lfsr_step_unroll.sv
// -----------------------------------------------------------------------------
// lfsr_step_unroll
// Combinational chain of STEPS single Fibonacci shifts. Each shift moves the
// register one place towards the MSB and inserts the XOR of the tapped bits at
// bit 0. Purely combinational; no clock or reset.
//   state_i : current register value
//   state_o : value after STEPS chained shifts (may be zero; caller handles lockup)
// -----------------------------------------------------------------------------
module lfsr_step_unroll
    import lfsr_pkg::*;
#(
    parameter int unsigned        LFSR_SIZE = LFSR_DEF_SIZE,
    parameter logic [LFSR_SIZE:0] LFSR_POLY = LFSR_DEF_POLY,
    parameter int unsigned        STEPS     = 1
) (
    input  logic [LFSR_SIZE-1:0] state_i,
    output logic [LFSR_SIZE-1:0] state_o
);

    // Tap mask aligned with the state bits; POLY[0] is the implicit x^0 term.
    localparam logic [LFSR_SIZE-1:0] TAPS = LFSR_POLY[LFSR_SIZE:1];

    logic [LFSR_SIZE-1:0] chain [STEPS+1];

    assign chain[0] = state_i;

    for (genvar k = 0; k < STEPS; k++) begin : g_step
        assign chain[k+1] = {chain[k][LFSR_SIZE-2:0],
                             lfsr_fb(LFSR_MAX'(chain[k]), LFSR_MAX'(TAPS))};
    end

    assign state_o = chain[STEPS];

endmodule

// File: rtl/lfsr_stream.sv
// -----------------------------------------------------------------------------
// lfsr_stream
// Seedable Fibonacci LFSR word source with a valid/ready output handshake.
// The register advances STEPS single shifts per accepted word, discards WARMUP
// advances after reset or a seed load, and never holds the all-zero state.
//
// Ports
//   clk         : clock
//   reset       : synchronous, active-high; overrides everything
//   seed_valid  : load seed_data at the next edge (wins over advance/warm-up)
//   seed_data   : new seed; zero is replaced by LFSR_INIT
//   out_ready   : consumer accepts data_out when out_valid is high
//   out_valid   : data_out holds a deliverable word
//   data_out    : current LFSR state
//   seed_zero   : one-cycle pulse after an all-zero seed was rejected
//   period_done : (LFSR_PERIOD_MON_EN only) one-cycle pulse when an advance
//                 returns the register to the last loaded seed / LFSR_INIT
//
// Optional feature macro: LFSR_PERIOD_MON_EN (period monitor, adds period_done).
// -----------------------------------------------------------------------------
module lfsr_stream
    import lfsr_pkg::*;
#(
    parameter int unsigned          LFSR_SIZE = LFSR_DEF_SIZE,
    parameter logic [LFSR_SIZE:0]   LFSR_POLY = LFSR_DEF_POLY,
    parameter logic [LFSR_SIZE-1:0] LFSR_INIT = LFSR_DEF_INIT,
    parameter int unsigned          STEPS     = 1,
    parameter int unsigned          WARMUP    = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 seed_valid,
    input  logic [LFSR_SIZE-1:0] seed_data,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [LFSR_SIZE-1:0] data_out,
    output logic                 seed_zero
`ifdef LFSR_PERIOD_MON_EN
    ,
    output logic                 period_done
`endif
);

    localparam logic [WARMUP_CNT_W-1:0] WARM_CNT   = WARMUP_CNT_W'(WARMUP);
    localparam lfsr_state_e             LOAD_STATE = (WARMUP > 0) ? ST_WARMUP : ST_RUN;
    // out_valid right after a seed load: only a warm-up phase hides the word.
    localparam logic                    LOAD_VALID = (WARMUP == 0);

    lfsr_state_e             state_q;
    logic [WARMUP_CNT_W-1:0] warm_cnt_q;
    logic [LFSR_SIZE-1:0]    lfsr_q;
    logic                    out_valid_q;
    logic                    seed_zero_q;

    logic [LFSR_SIZE-1:0]    adv_raw;
    logic [LFSR_SIZE-1:0]    adv_state;
    logic [LFSR_SIZE-1:0]    seed_value;
    logic                    seed_is_zero;
    logic                    fire;
    logic                    adv_en;

    lfsr_step_unroll #(
        .LFSR_SIZE (LFSR_SIZE),
        .LFSR_POLY (LFSR_POLY),
        .STEPS     (STEPS)
    ) u_step (
        .state_i (lfsr_q),
        .state_o (adv_raw)
    );

    always_comb begin
        // A non-primitive polynomial can fall into zero; restart from INIT.
        adv_state    = (adv_raw == '0) ? LFSR_INIT : adv_raw;
        seed_is_zero = (seed_data == '0);
        seed_value   = seed_is_zero ? LFSR_INIT : seed_data;
        fire         = out_valid_q && out_ready;
        // The seed overrides any advance in the same cycle, even an accepted
        // transfer: the consumer still takes the old word.
        adv_en       = !seed_valid && ((state_q == ST_WARMUP) || fire);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= LOAD_STATE;
            warm_cnt_q  <= WARM_CNT;
            lfsr_q      <= LFSR_INIT;
            out_valid_q <= 1'b0;
            seed_zero_q <= 1'b0;
        end else begin
            seed_zero_q <= 1'b0;
            if (adv_en) begin
                lfsr_q <= adv_state;
            end
            if (seed_valid) begin
                lfsr_q      <= seed_value;
                seed_zero_q <= seed_is_zero;
                warm_cnt_q  <= WARM_CNT;
                state_q     <= LOAD_STATE;
                out_valid_q <= LOAD_VALID;
            end else begin
                unique case (state_q)
                    ST_WARMUP: begin
                        warm_cnt_q <= warm_cnt_q - 8'd1;
                        // Leave warm-up on the advance that drains the counter.
                        if (warm_cnt_q == 8'd1) begin
                            state_q     <= ST_RUN;
                            out_valid_q <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        // Also raises out_valid one cycle after a reset into RUN.
                        out_valid_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign out_valid = out_valid_q;
    assign data_out  = lfsr_q;
    assign seed_zero = seed_zero_q;

`ifdef LFSR_PERIOD_MON_EN
    logic [LFSR_SIZE-1:0] seed_ref_q;
    logic [LFSR_SIZE-1:0] step_cnt_q;
    logic                 period_done_q;

    // step_cnt_q counts advances since the last load or completed period.
    always_ff @(posedge clk) begin
        if (reset) begin
            seed_ref_q    <= LFSR_INIT;
            step_cnt_q    <= '0;
            period_done_q <= 1'b0;
        end else begin
            period_done_q <= 1'b0;
            if (seed_valid) begin
                seed_ref_q <= seed_value;
                step_cnt_q <= '0;
            end else if (adv_en) begin
                if (adv_state == seed_ref_q) begin
                    period_done_q <= 1'b1;
                    step_cnt_q    <= '0;
                end else begin
                    step_cnt_q <= step_cnt_q + 1'b1;
                end
            end
        end
    end

    assign period_done = period_done_q;
`endif

endmodule

// File: tb/tb_lfsr_stream.sv
// -----------------------------------------------------------------------------
// tb_lfsr_stream
// Three lfsr_stream configurations share one stimulus stream:
//   inst 0 : STEPS=1, WARMUP=0
//   inst 1 : STEPS=4, WARMUP=0
//   inst 2 : STEPS=1, WARMUP=2
// Each is tracked by a cycle-level reference model built from the stream rules
// (integer state, remaining warm-up advances, valid flag). Directed sequences
// pin known values first, then a long randomized run compares every cycle.
// -----------------------------------------------------------------------------
module tb_lfsr_stream;

    localparam int N      = 3;
    localparam int SIZE   = 7;
    localparam int MASK   = 'h7f;
    localparam int TAPS   = 'h60;  // polynomial 8'b11000001 without its x^0 term
    localparam int INIT   = 'h7a;  // 7'b1111010

    localparam int STEPS_OF [N] = '{1, 4, 1};
    localparam int WARM_OF  [N] = '{0, 0, 2};

    logic            clk;
    logic            reset;
    logic            seed_valid;
    logic [SIZE-1:0] seed_data;
    logic            out_ready;
    logic            ov   [N];
    logic [SIZE-1:0] dout [N];
    logic            sz   [N];
`ifdef LFSR_PERIOD_MON_EN
    logic            pd   [N];
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int m_s    [N];
    int m_left [N];
    bit m_v    [N];
    bit m_z    [N];

    lfsr_stream #(.STEPS(1), .WARMUP(0)) dut0 (
        .clk(clk), .reset(reset), .seed_valid(seed_valid), .seed_data(seed_data),
        .out_ready(out_ready), .out_valid(ov[0]), .data_out(dout[0]), .seed_zero(sz[0])
`ifdef LFSR_PERIOD_MON_EN
        , .period_done(pd[0])
`endif
    );

    lfsr_stream #(.STEPS(4), .WARMUP(0)) dut1 (
        .clk(clk), .reset(reset), .seed_valid(seed_valid), .seed_data(seed_data),
        .out_ready(out_ready), .out_valid(ov[1]), .data_out(dout[1]), .seed_zero(sz[1])
`ifdef LFSR_PERIOD_MON_EN
        , .period_done(pd[1])
`endif
    );

    lfsr_stream #(.STEPS(1), .WARMUP(2)) dut2 (
        .clk(clk), .reset(reset), .seed_valid(seed_valid), .seed_data(seed_data),
        .out_ready(out_ready), .out_valid(ov[2]), .data_out(dout[2]), .seed_zero(sz[2])
`ifdef LFSR_PERIOD_MON_EN
        , .period_done(pd[2])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One shift: s * 2 modulo 2^7, plus the parity of the tapped bits.
    function automatic int shift1(input int s);
        int fb;
        fb = $countones(s & TAPS) % 2;
        return ((s * 2) + fb) % (MASK + 1);
    endfunction

    function automatic int advance(input int s, input int steps);
        int r;
        r = s;
        for (int k = 0; k < steps; k++) r = shift1(r);
        return (r == 0) ? INIT : r;
    endfunction

    // Apply the current inputs to the model for the coming edge.
    task automatic model_edge();
        for (int i = 0; i < N; i++) begin
            if (reset) begin
                m_s[i]    = INIT;
                m_left[i] = WARM_OF[i];
                m_v[i]    = 1'b0;
                m_z[i]    = 1'b0;
            end else if (seed_valid) begin
                m_s[i]    = (seed_data == 0) ? INIT : int'(seed_data);
                m_z[i]    = (seed_data == 0);
                m_left[i] = WARM_OF[i];
                m_v[i]    = (WARM_OF[i] == 0);
            end else begin
                m_z[i] = 1'b0;
                if (m_left[i] > 0) begin
                    m_s[i] = advance(m_s[i], STEPS_OF[i]);
                    m_left[i]--;
                    m_v[i] = (m_left[i] == 0);
                end else begin
                    if (m_v[i] && out_ready) m_s[i] = advance(m_s[i], STEPS_OF[i]);
                    m_v[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < N; i++) begin
            check_val($sformatf("inst%0d out_valid", i), 32'(ov[i]), 32'(m_v[i]));
            check_val($sformatf("inst%0d data_out", i), 32'(dout[i]), 32'(m_s[i]));
            check_val($sformatf("inst%0d seed_zero", i), 32'(sz[i]), 32'(m_z[i]));
        end
    endtask

    // Drive inputs, advance one clock, sample on the falling edge.
    task automatic tick(input bit rst, input bit sv, input logic [SIZE-1:0] sd,
                        input bit rdy);
        reset      = rst;
        seed_valid = sv;
        seed_data  = sd;
        out_ready  = rdy;
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        reset      = 1'b1;
        seed_valid = 1'b0;
        seed_data  = '0;
        out_ready  = 1'b1;

        // Reset state and first words
        tick(1, 0, 0, 1);
        check_val("reset out_valid", 32'(ov[0]), 0);
        check_val("reset data_out", 32'(dout[0]), 32'h7a);
        check_val("reset seed_zero", 32'(sz[0]), 0);
        tick(0, 0, 0, 1);
        check_val("post-reset valid low warmup", 32'(ov[2]), 0);
        check_val("first word", 32'(dout[0]), 32'h7a);
        check_val("first valid", 32'(ov[0]), 1);
        tick(0, 0, 0, 1);
        check_val("seq step1", 32'(dout[0]), 32'h74);
        check_val("steps4 word", 32'(dout[1]), 32'h21);
        check_val("warmup valid", 32'(ov[2]), 1);
        check_val("warmup data", 32'(dout[2]), 32'h68);
        tick(0, 0, 0, 1);
        check_val("seq step2", 32'(dout[0]), 32'h68);
        tick(0, 0, 0, 1);
        check_val("seq step3", 32'(dout[0]), 32'h50);
        tick(0, 0, 0, 1);
        check_val("seq step4", 32'(dout[0]), 32'h21);

        // Stall: data held while out_ready is low
        for (int k = 0; k < 5; k++) begin
            tick(0, 0, 0, 0);
            check_val("stall hold", 32'(dout[0]), 32'h21);
        end

        // Seed together with an accepted word: seed wins, no extra advance
        tick(0, 1, 7'h01, 1);
        check_val("seed+accept data", 32'(dout[0]), 32'h01);
        check_val("seed valid kept", 32'(ov[0]), 1);
        check_val("seed warmup valid drop", 32'(ov[2]), 0);

        // Zero seed substitution
        tick(0, 1, 7'h00, 1);
        check_val("zero seed data", 32'(dout[0]), 32'h7a);
        check_val("zero seed pulse", 32'(sz[0]), 1);
        tick(0, 0, 0, 0);
        check_val("zero seed pulse end", 32'(sz[0]), 0);

`ifdef LFSR_PERIOD_MON_EN
        // Full period from reset: pulse right after the 127th accepted word
        tick(1, 0, 0, 1);
        tick(0, 0, 0, 1);
        for (int k = 1; k <= 127; k++) begin
            tick(0, 0, 0, 1);
            check_val($sformatf("period_done word %0d", k), 32'(pd[0]), 32'(k == 127));
        end
        check_val("period data", 32'(dout[0]), 32'h7a);
`endif

        // Randomized run against the model
        for (int c = 0; c < 3000; c++) begin
            bit          r_rst;
            bit          r_sv;
            bit          r_rdy;
            logic [SIZE-1:0] r_sd;
            r_rst = ($urandom_range(0, 59) == 0);
            r_sv  = ($urandom_range(0, 15) == 0);
            r_sd  = ($urandom_range(0, 3) == 0) ? 7'h00 : SIZE'($urandom);
            r_rdy = ($urandom_range(0, 3) != 0);
            tick(r_rst, r_sv, r_sd, r_rdy);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
